// File: rtl/cdb_arbiter_if.sv
// Bundle of requester-side and broadcast-side signals of the common data bus arbiter.
// The arbiter takes the slave view; the requesters and broadcast listeners take the master view.
interface cdb_arbiter_if #(
    parameter int N_REQ  = 6,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_grant;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic                    tag_err;
    logic [15:0]             bcast_cnt;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_grant, cdb_valid, cdb_tag, cdb_data, tag_err, bcast_cnt
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_grant, cdb_valid, cdb_tag, cdb_data, tag_err, bcast_cnt
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: combinational one-hot grant,
// registered broadcast of the winner's tag/data one cycle later.
module cdb_arbiter #(
    parameter int N_REQ  = 6,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          reset,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_REQ);

    logic [TAG_W-1:0]  tag_arr  [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];
    logic [N_REQ-1:0]  elig;
    logic              any_zero_tag;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic              tag_err_q, tag_err_d;
    logic [15:0]       bcast_cnt_q, bcast_cnt_d;

    logic [PTR_W-1:0]  gidx;
    logic              gfound;
    logic [PTR_W:0]    scan_idx;
    logic [PTR_W:0]    ptr_next;
    logic [N_REQ-1:0]  grant;

    // Unpack the flat request buses; tag 0 is reserved and makes a request ineligible.
    always_comb begin
        elig         = '0;
        any_zero_tag = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            tag_arr[i]  = bus.req_tag[i*TAG_W +: TAG_W];
            data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
            elig[i]     = bus.req_valid[i] && (tag_arr[i] != '0);
            if (bus.req_valid[i] && (tag_arr[i] == '0)) begin
                any_zero_tag = 1'b1;
            end
        end
    end

    // Scan ptr, ptr+1, ... modulo N_REQ; the first eligible index wins.
    always_comb begin
        grant    = '0;
        gidx     = '0;
        gfound   = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (scan_idx >= N_EXT) begin
                scan_idx = scan_idx - N_EXT;
            end
            if (!gfound && elig[scan_idx[PTR_W-1:0]]) begin
                gfound = 1'b1;
                gidx   = scan_idx[PTR_W-1:0];
            end
        end
        if (reset) begin
            gfound = 1'b0;
        end
        if (gfound) begin
            grant[gidx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        bcast_cnt_d = bcast_cnt_q;
        tag_err_d   = tag_err_q | any_zero_tag;
        ptr_next    = '0;
        if (gfound) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = tag_arr[gidx];
            cdb_data_d  = data_arr[gidx];
            bcast_cnt_d = bcast_cnt_q + 16'd1;
            ptr_next    = {1'b0, gidx} + {{PTR_W{1'b0}}, 1'b1};
            if (ptr_next == N_EXT) begin
                ptr_next = '0;
            end
            ptr_d = ptr_next[PTR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            tag_err_q   <= 1'b0;
            bcast_cnt_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            tag_err_q   <= tag_err_d;
            bcast_cnt_q <= bcast_cnt_d;
        end
    end

    assign bus.req_grant = grant;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.tag_err   = tag_err_q;
    assign bus.bcast_cnt = bcast_cnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: hand-derived grant vectors plus a scoreboard of
// expected broadcasts checked one cycle after each grant.
module tb_cdb_arbiter;
    localparam int N  = 6;
    localparam int TW = 4;
    localparam int DW = 32;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_g;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    exp_t          sb[$];
    logic [15:0]   m_cnt;
    logic          m_tag_err;
    logic [TW-1:0] last_tag;
    logic [DW-1:0] last_data;
    vec_t          vt[9];

    cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*TW-1:0] std_tags();
        logic [N*TW-1:0] t;
        t = '0;
        for (int i = 0; i < N; i++) t[i*TW +: TW] = TW'(i + 1);
        return t;
    endfunction

    function automatic logic [N*DW-1:0] std_data(input int k);
        logic [N*DW-1:0] d;
        d = '0;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 32'hC0DE_0000 + 32'(k * 256 + i);
        return d;
    endfunction

    task automatic model_clear();
        sb.delete();
        m_cnt     = 16'd0;
        m_tag_err = 1'b0;
        last_tag  = '0;
        last_data = '0;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    // One cycle: drive at edge+1, check grant at edge+2, check broadcast at next edge+1.
    task automatic step(input logic [N-1:0] v, input logic [N*TW-1:0] t,
                        input logic [N*DW-1:0] d, input logic [N-1:0] eg, input string nm);
        exp_t e;
        bus.req_valid = v;
        bus.req_tag   = t;
        bus.req_data  = d;
        #1;
        chk({nm, "_grant"}, 64'(bus.req_grant), 64'(eg));
        for (int i = 0; i < N; i++) begin
            if (v[i] && (t[i*TW +: TW] == '0)) m_tag_err = 1'b1;
            if (eg[i]) begin
                e.tag  = t[i*TW +: TW];
                e.data = d[i*DW +: DW];
                sb.push_back(e);
                m_cnt = m_cnt + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({nm, "_cdb_valid"}, 64'(bus.cdb_valid), 64'(1'b1));
            chk({nm, "_cdb_tag"}, 64'(bus.cdb_tag), 64'(e.tag));
            chk({nm, "_cdb_data"}, 64'(bus.cdb_data), 64'(e.data));
            last_tag  = e.tag;
            last_data = e.data;
        end else begin
            chk({nm, "_cdb_valid"}, 64'(bus.cdb_valid), 64'(1'b0));
            chk({nm, "_cdb_tag_hold"}, 64'(bus.cdb_tag), 64'(last_tag));
            chk({nm, "_cdb_data_hold"}, 64'(bus.cdb_data), 64'(last_data));
        end
        chk({nm, "_bcast_cnt"}, 64'(bus.bcast_cnt), 64'(m_cnt));
        chk({nm, "_tag_err"}, 64'(bus.tag_err), 64'(m_tag_err));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        model_clear();

        // Expected grants walk the round-robin pointer by hand, starting from ptr=0.
        vt[0] = '{6'b000100, 6'b000100};  // ptr -> 3
        vt[1] = '{6'b000011, 6'b000001};  // 3,4,5 empty, wraps to 0; ptr -> 1
        vt[2] = '{6'b110000, 6'b010000};  // ptr -> 5
        vt[3] = '{6'b110000, 6'b100000};  // ptr -> 0
        vt[4] = '{6'b000000, 6'b000000};  // ptr holds 0
        vt[5] = '{6'b111111, 6'b000001};  // ptr -> 1
        vt[6] = '{6'b101000, 6'b001000};  // ptr -> 4
        vt[7] = '{6'b001001, 6'b000001};  // 4,5 empty, wraps to 0; ptr -> 1
        vt[8] = '{6'b000010, 6'b000010};  // ptr -> 2

        do_reset();
        #1;
        chk("rst_grant", 64'(bus.req_grant), 64'(0));
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'(0));
        chk("rst_cdb_tag", 64'(bus.cdb_tag), 64'(0));
        chk("rst_cdb_data", 64'(bus.cdb_data), 64'(0));
        chk("rst_tag_err", 64'(bus.tag_err), 64'(0));
        chk("rst_bcast_cnt", 64'(bus.bcast_cnt), 64'(0));
        @(posedge clk);
        #1;

        step(6'b000100, 24'h000500, 192'h1234 << 64, 6'b000100, "single");

        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(vt[k].valid, std_tags(), std_data(k), vt[k].exp_g, $sformatf("vec%0d", k));
        end

        do_reset();
        for (int k = 0; k < 7; k++) begin
            step(6'b111111, std_tags(), std_data(20 + k), 6'(1 << (k % N)), $sformatf("rr%0d", k));
        end

        do_reset();
        step(6'b001000, std_tags(), std_data(40), 6'b001000, "wrap_set");
        step(6'b100010, std_tags(), std_data(41), 6'b100000, "wrap_first");
        step(6'b000010, std_tags(), std_data(42), 6'b000010, "wrap_second");
        step(6'b000111, std_tags(), std_data(43), 6'b000100, "wrap_ptr2");

        do_reset();
        step(6'b000001, '0, std_data(50), 6'b000000, "tag0");
        for (int k = 0; k < 10; k++) begin
            step(6'b000000, std_tags(), std_data(51), 6'b000000, $sformatf("tag0_hold%0d", k));
        end

        do_reset();
        step(6'b000100, std_tags(), std_data(60), 6'b000100, "mid_set");
        bus.req_valid = 6'b010011;
        bus.req_tag   = std_tags();
        bus.req_data  = std_data(61);
        reset = 1'b1;
        #1;
        chk("mid_rst_grant", 64'(bus.req_grant), 64'(0));
        @(posedge clk);
        #1;
        chk("mid_rst_cdb_valid", 64'(bus.cdb_valid), 64'(0));
        chk("mid_rst_bcast_cnt", 64'(bus.bcast_cnt), 64'(0));
        reset = 1'b0;
        model_clear();
        step(6'b010011, std_tags(), std_data(61), 6'b000001, "mid_release");

        do_reset();
        bus.req_valid = 6'b000001;
        bus.req_tag   = std_tags();
        bus.req_data  = std_data(70);
        repeat (65535) @(posedge clk);
        #1;
        chk("cnt_ffff", 64'(bus.bcast_cnt), 64'(16'hFFFF));
        @(posedge clk);
        #1;
        chk("cnt_wrap", 64'(bus.bcast_cnt), 64'(16'h0000));
        chk("cnt_wrap_valid", 64'(bus.cdb_valid), 64'(1));
        bus.req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
- REQ-001 Parameter N_REQ, default 6: number of requesters; index order is adder1, adder2, adder3, multi1, multi2, mem.
- REQ-002 Parameter TAG_W, default 4: tag width.
- REQ-003 Parameter DATA_W, default 32: broadcast data width.
- REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-005 Port reset, input, 1: synchronous, active-high reset.
- REQ-006 Port req_valid, input, N_REQ: requester i has a result to broadcast.
- REQ-007 Port req_tag, input, N_REQ*TAG_W: tag of requester i, packed at bits [i*TAG_W +: TAG_W].
- REQ-008 Port req_data, input, N_REQ*DATA_W: data of requester i, packed at bits [i*DATA_W +: DATA_W].
- REQ-009 Port req_grant, output, N_REQ: one-hot or zero; combinational grant for the current cycle.
- REQ-010 Port cdb_valid, output, 1: registered broadcast-valid flag.
- REQ-011 Port cdb_tag, output, TAG_W: registered broadcast tag.
- REQ-012 Port cdb_data, output, DATA_W: registered broadcast data.
- REQ-013 Port tag_err, output, 1: sticky flag; set when a valid request carries tag 0.
- REQ-014 Port bcast_cnt, output, 16: count of broadcasts issued since reset.

Function
- REQ-015 Internal round-robin pointer ptr, range 0..N_REQ-1.
- REQ-016 Eligible request: req_valid[i]=1 and req_tag[i]!=0.
- REQ-017 req_grant selects the first eligible index scanning ptr, ptr+1, ..., wrapping modulo N_REQ; req_grant is all-zero when none is eligible.
- REQ-018 At most one req_grant bit is high in any cycle.
- REQ-019 Handshake: a requester holds req_valid, req_tag and req_data stable until it sees req_grant[i]=1, and deasserts or presents its next result in the following cycle.
- REQ-020 On a grant to index g, at the next edge: cdb_valid<=1, cdb_tag<=req_tag[g], cdb_data<=req_data[g], ptr<=(g+1) mod N_REQ, bcast_cnt<=bcast_cnt+1.
- REQ-021 With no grant, at the next edge: cdb_valid<=0, cdb_tag and cdb_data hold their values, ptr holds, bcast_cnt holds.
- REQ-022 Latency: exactly 1 cycle from grant to cdb_valid; back-to-back grants give one broadcast every cycle.
- REQ-023 Fairness: a continuously eligible requester is granted within N_REQ cycles.
- REQ-024 A request with valid=1 and tag=0 is never granted; tag_err<=1 at the next edge and stays set until reset.
- REQ-025 bcast_cnt wraps from 0xFFFF to 0x0000 without a flag.
- REQ-026 ptr wraps from N_REQ-1 to 0.
- REQ-027 A requester that drops req_valid before being granted loses its place; this is not an error.

Reset
- REQ-028 When reset=1 at an edge: ptr<=0, cdb_valid<=0, cdb_tag<=0, cdb_data<=0, tag_err<=0, bcast_cnt<=0.
- REQ-029 req_grant is forced to all-zero while reset=1, including when reset asserts mid-stream.
- REQ-030 Pending requests present when reset releases are arbitrated from ptr=0 in the first cycle after release.

Verification
- REQ-031 Single request: after reset, req_valid=000100 with tag 5, data 0x1234 -> req_grant=000100 the same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=0x1234; bcast_cnt=1.
- REQ-032 All six requesters held valid with tags 1..6 -> grants in order 0,1,2,3,4,5,0; cdb_valid=1 for six consecutive cycles; cdb_tag sequence 1..6.
- REQ-033 Wrap case: ptr=4 with requesters 1 and 5 valid -> requester 5 is granted first, then requester 1; ptr ends at 2.
- REQ-034 Tag-zero case: req_valid=000001 with tag 0 -> req_grant=0, cdb_valid=0 next cycle, tag_err=1 and still 1 after 10 further cycles.
- REQ-035 Reset mid-stream: three requesters pending and ptr=3; assert reset for one cycle -> req_grant=0 and cdb_valid=0 during reset; after release the lowest-index pending requester is granted.
- REQ-036 Counter wrap: with bcast_cnt forced to 0xFFFF and one grant issued -> bcast_cnt=0x0000 and cdb_valid=1.
